// File: rtl/pwm_update_arbiter.sv
// Shares one PWM generator config port among NUM_REQ requesters and issues one clamped update per PWM period.
// Define PWM_ARB_FIXED_PRIO_EN for fixed-priority arbitration (lowest index wins); default is round-robin.
module pwm_update_arbiter #(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned TIMEOUT   = 0,
    parameter logic [7:0]  RESET_TOP = 8'hff
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic [8*NUM_REQ-1:0]       i_req_top,
    input  logic [9*NUM_REQ-1:0]       i_req_compare,
    input  logic                       i_period_end,
    output logic [7:0]                 o_top,
    output logic                       o_top_valid,
    output logic [8:0]                 o_compare,
    output logic                       o_compare_valid,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
    output logic                       o_busy
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        ISSUE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [7:0]       top_hold_q, top_hold_d;
    logic [8:0]       cmp_hold_q, cmp_hold_d;
    logic [7:0]       top_q, top_d;
    logic [8:0]       cmp_q, cmp_d;
    logic             valid_q, valid_d;

    logic             win_found;
    logic [ID_W-1:0]  win_idx;
    logic             xfer;
    logic [7:0]       top_sel;
    logic [8:0]       cmp_sel;
    logic [8:0]       top_p1;
    logic [8:0]       cmp_clamped;
    logic             timed_out;

`ifdef PWM_ARB_FIXED_PRIO_EN
    // Lowest-index valid requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!win_found && i_req_valid[i]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] ptr_q, ptr_d;

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!win_found && i_req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign xfer        = (state_q == IDLE) && win_found;
    assign o_req_ready = NUM_REQ'(xfer) << win_idx;

    // Compare above top+1 would never match; saturate to 100% duty.
    assign top_sel     = i_req_top[8*win_idx +: 8];
    assign cmp_sel     = i_req_compare[9*win_idx +: 9];
    assign top_p1      = {1'b0, top_sel} + 9'd1;
    assign cmp_clamped = (cmp_sel > top_p1) ? top_p1 : cmp_sel;

    assign timed_out = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        top_hold_d = top_hold_q;
        cmp_hold_d = cmp_hold_q;
        top_d      = top_q;
        cmp_d      = cmp_q;
        valid_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    top_hold_d = top_sel;
                    cmp_hold_d = cmp_clamped;
                    grant_d    = win_idx;
                    cnt_d      = '0;
                    state_d    = HELD;
                end
            end
            HELD: begin
                if (i_period_end || timed_out) begin
                    top_d   = top_hold_q;
                    cmp_d   = cmp_hold_q;
                    valid_d = 1'b1;
                    state_d = ISSUE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ISSUE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            grant_q    <= '0;
            top_hold_q <= '0;
            cmp_hold_q <= '0;
            top_q      <= RESET_TOP;
            cmp_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            top_hold_q <= top_hold_d;
            cmp_hold_q <= cmp_hold_d;
            top_q      <= top_d;
            cmp_q      <= cmp_d;
            valid_q    <= valid_d;
        end
    end

    assign o_top           = top_q;
    assign o_compare       = cmp_q;
    assign o_top_valid     = valid_q;
    assign o_compare_valid = valid_q;
    assign o_grant_id      = grant_q;
    assign o_busy          = (state_q != IDLE);

endmodule
